// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-voted sampling,
// parity/framing/overrun flags and a valid/ready holding register.
module uart_rx_param #(
    parameter int CLK_HZ    = 125000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t state, state_nx;

    logic                 s1, s2, s3, v0, v1, sidx, perr, ferr;
    logic [CW-1:0]        cnt;
    logic [2:0]           bidx;
    logic [DATA_BITS-1:0] sh;
    logic                 fall, wrap, vote_t, vote, last_data, last_stop, done, accept;

    assign fall      = s3 & ~s2;
    assign wrap      = cnt == CW'(CPB - 1);
    assign vote_t    = cnt == CW'(HALF + 1);
    assign vote      = (v0 & v1) | (v0 & s2) | (v1 & s2);
    assign last_data = bidx == 3'(DATA_BITS - 1);
    assign last_stop = sidx == 1'(STOP_BITS - 1);
    assign accept    = ~data_valid | data_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fall) state_nx = START;
            START:   state_nx = (vote_t && vote) ? IDLE : wrap ? DATA : START;
            DATA:    if (wrap && last_data) state_nx = (PARITY != 0) ? PAR : STOP;
            PAR:     if (wrap) state_nx = STOP;
            STOP:    if (vote_t && last_stop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        done = (state == STOP) && vote_t && last_stop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s3}                        <= 3'b111;
            {v0, v1, sidx, perr, ferr}          <= '0;
            cnt                                 <= '0;
            bidx                                <= '0;
            sh                                  <= '0;
            data_out                            <= '0;
            {data_valid, parity_err, frame_err} <= '0;
            overrun_err                         <= 1'b0;
        end else begin
            {s1, s2, s3} <= {rxd, s1, s2};
            cnt <= (state == IDLE || state_nx == IDLE || wrap) ? '0 : cnt + 1'b1;
            if (cnt == CW'(HALF - 1)) v0 <= s2;
            if (cnt == CW'(HALF)) v1 <= s2;
            if (state == IDLE) {bidx, sidx, perr, ferr} <= '0;
            if (state == DATA && vote_t) sh <= {vote, sh[DATA_BITS-1:1]};
            if (state == DATA && wrap) bidx <= last_data ? 3'd0 : bidx + 3'd1;
            // odd parity expects data^parity == 1, even expects 0
            if (state == PAR && vote_t) perr <= vote ^ (^sh) ^ (PARITY == 1);
            if (state == STOP && vote_t && !vote) ferr <= 1'b1;
            if (state == STOP && wrap) sidx <= 1'b1;
            overrun_err <= done & ~accept;
            if (done && accept) begin
                data_out   <= sh;
                parity_err <= perr;
                frame_err  <= ferr | ~vote;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end
endmodule
